stage_threshold_eval: RTL and testbench

- Consumer side of the stage-threshold ROM in the cascade classifier.
- For each candidate window, walks stages 0..N_STAGES-1 and drives the ROM read port (ena/addra) to fetch each stage threshold (1-cycle read latency).
- Accumulates signed weak-classifier votes arriving on a valid/ready stream and compares each stage sum against its threshold.
- Reports reject (with failing stage index) or detect (all stages passed) to the window scheduler.

---
 rtl/stage_threshold_eval.sv | 138 +++++++++++++
 tb/tb_stage_threshold_eval.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_threshold_eval.sv
// Cascade stage-threshold evaluator: walks the threshold ROM per window,
// accumulates saturating signed votes and reports detect or reject stage.
module stage_threshold_eval #(
  parameter int W_DATA   = 11,
  parameter int W_ADDR   = 5,
  parameter int N_STAGES = 25,
  parameter int W_VOTE   = 14,
  parameter int W_SUM    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              rom_ena,
  output logic [W_ADDR-1:0] rom_addra,
  input  logic [W_DATA-1:0] rom_doa,
  input  logic              vote_valid,
  output logic              vote_ready,
  input  logic [W_VOTE-1:0] vote_data,
  input  logic              vote_last,
  output logic              result_valid,
  output logic              result_detect,
  output logic [W_ADDR-1:0] result_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ACCUM,
    S_DECIDE
  } state_t;

  localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);

  state_t                   state_q, state_d;
  logic [W_ADDR-1:0]        stage_q, stage_d;
  logic signed [W_SUM-1:0]  acc_q, acc_d;
  logic signed [W_SUM-1:0]  thr_q, thr_d;
  logic                     res_valid_q, res_valid_d;
  logic                     res_detect_q, res_detect_d;
  logic [W_ADDR-1:0]        res_stage_q, res_stage_d;

  logic signed [W_SUM:0]    vote_sum;
  logic signed [W_SUM-1:0]  acc_sat;
  logic                     pass;

  // One extra bit of headroom is enough: both operands fit in W_SUM bits.
  always_comb begin
    vote_sum = {acc_q[W_SUM-1], acc_q}
             + {{(W_SUM + 1 - W_VOTE){vote_data[W_VOTE-1]}}, vote_data};
    if (vote_sum[W_SUM] != vote_sum[W_SUM-1]) begin
      acc_sat = {vote_sum[W_SUM], {(W_SUM - 1){~vote_sum[W_SUM]}}};
    end else begin
      acc_sat = vote_sum[W_SUM-1:0];
    end
    pass = (acc_q >= thr_q);
  end

  // Next-state and datapath update for the stage walk.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    acc_d        = acc_q;
    thr_d        = thr_q;
    res_valid_d  = 1'b0;
    res_detect_d = res_detect_q;
    res_stage_d  = res_stage_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          stage_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        thr_d   = {{(W_SUM - W_DATA){rom_doa[W_DATA-1]}}, rom_doa};
        acc_d   = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (vote_valid) begin
          acc_d = acc_sat;
          if (vote_last) begin
            state_d = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        if (!pass || stage_q == LAST_STAGE) begin
          res_valid_d  = 1'b1;
          res_detect_d = pass;
          res_stage_d  = stage_q;
          state_d      = S_IDLE;
        end else begin
          stage_d = stage_q + W_ADDR'(1);
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      acc_q        <= '0;
      thr_q        <= '0;
      res_valid_q  <= 1'b0;
      res_detect_q <= 1'b0;
      res_stage_q  <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      res_valid_q  <= res_valid_d;
      res_detect_q <= res_detect_d;
      res_stage_q  <= res_stage_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign rom_ena       = (state_q == S_FETCH);
  assign rom_addra     = stage_q;
  assign vote_ready    = (state_q == S_ACCUM);
  assign result_valid  = res_valid_q;
  assign result_detect = res_detect_q;
  assign result_stage  = res_stage_q;

endmodule

// File: tb/tb_stage_threshold_eval.sv
// Scoreboard bench for stage_threshold_eval: ROM model, vote driver,
// reference cascade model and a result monitor.
module tb_stage_threshold_eval;

  localparam int NS   = 25;
  localparam int SMAX = 131071;
  localparam int SMIN = -131072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        rom_ena;
  logic [4:0]  rom_addra;
  logic [10:0] rom_doa = '0;
  logic        vote_valid = 1'b0;
  logic        vote_ready;
  logic [13:0] vote_data = '0;
  logic        vote_last = 1'b0;
  logic        result_valid;
  logic        result_detect;
  logic [4:0]  result_stage;

  typedef struct {
    bit     det;
    int     stg;
    int     lat;
    longint t0;
  } exp_t;

  int     rom [NS];
  int     vq[$];
  bit     lq[$];
  exp_t   expq[$];
  int     rom_log[$];
  int     n_chk = 0;
  int     n_pass = 0;
  longint cyc = 0;

  stage_threshold_eval dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .rom_ena      (rom_ena),
    .rom_addra    (rom_addra),
    .rom_doa      (rom_doa),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .vote_data    (vote_data),
    .vote_last    (vote_last),
    .result_valid (result_valid),
    .result_detect(result_detect),
    .result_stage (result_stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok,
                       input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, req, cyc);
  endtask

  // Threshold ROM with one-cycle read latency, plus a log of read addresses.
  always @(posedge clk) begin
    int t;
    cyc <= cyc + 1;
    if (rom_ena) begin
      t = rom[rom_addra];
      rom_doa <= t[10:0];
    end
    if (rst) rom_log.delete();
    else if (rom_ena) rom_log.push_back(int'(rom_addra));
  end

  // Monitor: compare each result pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      if (vote_ready && !busy)
        check("ready_outside_busy", 1'b0, 1, 0);
      if (result_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_result", 1'b0, 1, 0);
        end else begin
          e = expq.pop_front();
          check("detect", result_detect == e.det, result_detect, e.det);
          check("stage", int'(result_stage) == e.stg, result_stage, e.stg);
          check("idle_at_result", !busy, busy, 0);
          if (e.lat >= 0)
            check("latency", (cyc - e.t0) == e.lat, cyc - e.t0, e.lat);
          ok = (rom_log.size() == e.stg + 1);
          foreach (rom_log[k]) if (rom_log[k] != k) ok = 1'b0;
          check("rom_reads", ok, rom_log.size(), e.stg + 1);
        end
        rom_log.delete();
      end
    end
  end

  function automatic int sat(input int a);
    if (a > SMAX) return SMAX;
    if (a < SMIN) return SMIN;
    return a;
  endfunction

  // Gap-free latency: one cycle to result, plus 3 + votes for each stage.
  function automatic int lat_of();
    int n = 1 + vq.size();
    foreach (lq[k]) if (lq[k]) n += 3;
    return n;
  endfunction

  task automatic add(input int v, input bit last);
    vq.push_back(v);
    lq.push_back(last);
  endtask

  task automatic begin_window(input bit push, input bit det,
                              input int stg, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (push) begin
      e.det = det;
      e.stg = stg;
      e.lat = lat;
      e.t0  = cyc;
      expq.push_back(e);
    end
  endtask

  task automatic drive(input int gap, input int poke);
    int  i = 0;
    int  guard = 0;
    int  t;
    bit  poked = 1'b0;
    bit  hs;
    while (i < vq.size()) begin
      @(negedge clk);
      start = 1'b0;
      if (poke >= 0 && !poked && vote_ready && int'(rom_addra) == poke) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (int'($urandom_range(99)) < gap) begin
        vote_valid = 1'b0;
        vote_data  = 14'($urandom);
        vote_last  = 1'b1;
      end else begin
        t = vq[i];
        vote_valid = 1'b1;
        vote_data  = t[13:0];
        vote_last  = lq[i];
      end
      hs = vote_valid && vote_ready;
      if (hs) i++;
      guard++;
      if (guard > 20000) begin
        check("drive_timeout", 1'b0, i, vq.size());
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    vote_valid = 1'b0;
    vote_last = 1'b0;
  endtask

  task automatic wait_result();
    for (int k = 0; k < 300 && expq.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (expq.size() != 0) begin
      check("result_timeout", 1'b0, expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic run(input bit det, input int stg, input int lat,
                     input int gap, input int poke);
    begin_window(1'b1, det, stg, lat);
    drive(gap, poke);
    wait_result();
  endtask

  // Reference cascade: random votes per stage, stop at first failing stage.
  task automatic gen_random(output bit det, output int stg);
    int acc;
    int k;
    int v;
    bit up;
    vq.delete();
    lq.delete();
    for (int s = 0; s < NS; s++) begin
      acc = 0;
      if ($urandom_range(9) == 0) begin
        k  = int'($urandom_range(20, 40));
        up = 1'($urandom_range(1));
        for (int j = 0; j < k; j++) begin
          v = ($urandom_range(3) == 0) ? (up ? -8192 : 8191)
                                       : (up ? 8191 : -8192);
          add(v, j == k - 1);
          acc = sat(acc + v);
        end
      end else begin
        k = int'($urandom_range(1, 4));
        for (int j = 0; j < k; j++) begin
          v = int'($urandom_range(500)) - 100;
          add(v, j == k - 1);
          acc = sat(acc + v);
        end
      end
      if (acc < rom[s]) begin
        det = 1'b0;
        stg = s;
        return;
      end
    end
    det = 1'b1;
    stg = NS - 1;
  endtask

  initial begin
    bit det;
    int stg;
    for (int s = 0; s < NS; s++) rom[s] = -514 + 6 * s;

    repeat (3) @(negedge clk);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_ready", vote_ready == 1'b0, vote_ready, 0);
    check("rst_rom_ena", rom_ena == 1'b0, rom_ena, 0);
    check("rst_addr", rom_addra == 5'd0, rom_addra, 0);
    check("rst_rvalid", result_valid == 1'b0, result_valid, 0);
    check("rst_rdetect", result_detect == 1'b0, result_detect, 0);
    check("rst_rstage", result_stage == 5'd0, result_stage, 0);
    rst = 1'b0;

    // Reject at stage 0.
    vq.delete(); lq.delete();
    add(-515, 1);
    run(1'b0, 0, 5, 0, -1);

    // Equality passes stage 0; reject at stage 1.
    vq.delete(); lq.delete();
    add(-300, 0); add(-214, 1); add(-509, 1);
    run(1'b0, 1, 10, 0, -1);

    // Full detect.
    vq.delete(); lq.delete();
    for (int s = 0; s < NS; s++) add(0, 1);
    run(1'b1, 24, 101, 0, -1);

    // Positive saturation passes stage 0, reject at stage 1.
    vq.delete(); lq.delete();
    for (int j = 0; j < 40; j++) add(8191, j == 39);
    add(-509, 1);
    run(1'b0, 1, 48, 0, -1);

    // Clamped sum differs from true sum: sat gives -1 < thr 0.
    rom[0] = 0;
    vq.delete(); lq.delete();
    for (int j = 0; j < 20; j++) add(8191, 0);
    for (int j = 0; j < 16; j++) add(-8192, j == 15);
    run(1'b0, 0, lat_of(), 0, -1);
    rom[0] = -514;

    // Start pulsed during stage 2 accumulation is ignored.
    vq.delete(); lq.delete();
    for (int s = 0; s < 4; s++) add(0, 1);
    add(-1000, 1);
    run(1'b0, 4, 21, 0, 2);
    repeat (10) @(negedge clk);

    // Reset during stage 3 accumulation aborts the window.
    vq.delete(); lq.delete();
    add(0, 1); add(0, 1); add(0, 1); add(5, 0);
    begin_window(1'b0, 1'b0, 0, 0);
    drive(0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy == 1'b0, busy, 0);
    check("abort_ready", vote_ready == 1'b0, vote_ready, 0);
    check("abort_rom_ena", rom_ena == 1'b0, rom_ena, 0);
    check("abort_addr", rom_addra == 5'd0, rom_addra, 0);
    check("abort_rvalid", result_valid == 1'b0, result_valid, 0);
    check("abort_rdetect", result_detect == 1'b0, result_detect, 0);
    check("abort_rstage", result_stage == 5'd0, result_stage, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vq.delete(); lq.delete();
    add(-515, 1);
    run(1'b0, 0, 5, 0, -1);

    // Randomized windows with random thresholds and backpressure.
    for (int w = 0; w < 40; w++) begin
      for (int s = 0; s < NS; s++) rom[s] = int'($urandom_range(800)) - 400;
      gen_random(det, stg);
      if (w % 2 == 0) run(det, stg, -1, 40, -1);
      else run(det, stg, lat_of(), 0, -1);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
